alu_sequencer: RTL
==================

# alu_sequencer

Multi-cycle controller that sequences the shared register-file/ALU datapath, one instruction at a time. It accepts a 16-bit instruction over a valid/ready handshake, decodes it, and steps a Moore state machine. That machine drives the register-file read/write ports, the A/B/C/status load enables, the operand selects and the 2-bit ALU operation code. It sits between the instruction source (fetch logic or testbench) and the datapath.

## Interface
- k, 16: datapath width; sets the width of `sximm8`.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- instr  input  16  instruction word: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [2:0] Rm, [7:0] imm8.
- instr_valid  input  1  `instr` is presented.
- instr_ready  output  1  sequencer can accept an instruction.
- done  output  1  one-cycle pulse in the final cycle of each instruction.
- illegal  output  1  one-cycle pulse when an undefined opcode/op is decoded.
- readnum  output  3  register-file read address.
- writenum  output  3  register-file write address.
- write  output  1  register-file write enable.
- loada, loadb, loadc, loads  output  1 each  datapath register enables (A, B, C, status).
- asel  output  1  1 forces the A operand to zero.
- vsel  output  1  write-back source: 0 = C, 1 = `sximm8`.
- alu_op  output  2  00 add, 01 sub, 10 and, 11 not-B.
- sximm8  output  k  imm8 sign-extended to k bits, taken from the latched instruction.

## Operation
- Supported instructions; anything else raises `illegal`:
  - opcode 110, op 10: MOV Rn, #imm8.
  - opcode 110, op 00: MOV Rd, Rm.
  - opcode 101, op 00: ADD Rd, Rn, Rm.
  - opcode 101, op 01: CMP Rn, Rm (status only).
  - opcode 101, op 10: AND Rd, Rn, Rm.
  - opcode 101, op 11: MVN Rd, Rm.
- States: IDLE, DECODE, WR_IMM, GET_A, GET_B, EXEC, WR_C, FAULT.
- Outputs are Moore: a decode of the state register and the latched instruction. Every control output is 0 unless listed for a state.
- IDLE: `instr_ready`=1. If `instr_valid` is high at a clock edge, the instruction is latched and the machine goes to DECODE.
- DECODE: no controls. Next state is:
  - WR_IMM for MOV #imm;
  - GET_A for ADD, CMP and AND;
  - GET_B for MOV reg and MVN;
  - FAULT for anything else.
- WR_IMM: `vsel`=1, `writenum`=Rn, `write`=1, `done`=1. Next: IDLE.
- GET_A: `readnum`=Rn, `loada`=1. Next: GET_B.
- GET_B: `readnum`=Rm, `loadb`=1. Next: EXEC.
- EXEC: `alu_op` is 00 for MOV reg, otherwise op. `asel`=1 for MOV reg and MVN.
  - CMP: `loads`=1, `done`=1. Next: IDLE.
  - All others: `loadc`=1, `loads`=1. Next: WR_C.
- WR_C: `vsel`=0, `writenum`=Rd, `write`=1, `done`=1. Next: IDLE.
- FAULT: `illegal`=1, `done`=1. Next: IDLE. Register file and status are untouched.
- `alu_op` is held at the instruction's value from DECODE through WR_C so the C input stays stable. It is 00 in IDLE.

## Timing
- Let the accept edge be cycle 0 (first cycle in DECODE = cycle 1). `done` is high in:
  - cycle 2 for MOV #imm;
  - cycle 3 for FAULT;
  - cycle 4 for CMP and MVN;
  - cycle 5 for ADD and AND;
  - cycle 4 for MOV reg (WR_C after EXEC? no: GET_B, EXEC, WR_C gives cycle 4).
- `instr_ready` rises in the cycle after `done`. Back-to-back throughput is therefore latency + 1 cycles.
- `instr_valid` is ignored outside IDLE. `instr` may change freely after acceptance because all fields come from the latched copy.
- Reset, at any time including mid-instruction: state goes to IDLE immediately (asynchronous). All outputs are 0 and the latched instruction clears to 0 while reset is high. `instr_ready` is held 0 during reset and becomes 1 in the first cycle after reset deasserts. An in-flight write is abandoned with no partial write.
- `done` and `illegal` are never high for more than one consecutive cycle.

## Structure
- Package `alu_seq_pkg`:
  - state enum;
  - opcode constants (OPC_MOV=3'b110, OPC_ALU=3'b101);
  - ALU op constants (ADD, SUB, AND, NOTB);
  - instruction field bit positions.
- Sub-module `instr_decode`: purely combinational. Maps the latched instruction to field values, `is_mov_imm`, `is_mov_reg`, `is_cmp`, `is_mvn`, `uses_a` and `legal`.
- Top-level logic: state register, instruction latch and the output decode.

## Test plan
- Reset, then MOV R3,#-2 (instr 16'hD3FE): `sximm8`=16'hFFFE, `write`=1 and `writenum`=3 in the cycle-2 state, `done` in cycle 2, `instr_ready` back high in cycle 3.
- ADD R2,R1,R0 (16'hA140): `readnum` is 1 then 0 in GET_A/GET_B; `loadc`=1 with `alu_op`=00 in EXEC; `write` with `writenum`=2 at cycle 5.
- CMP R1,R0 (16'hA940): `loads`=1 and `done`=1 in cycle 4; `write` never asserted.
- MVN R4,R5 (16'hB885): GET_A is skipped; `asel`=1 and `alu_op`=11 in EXEC; `writenum`=4 at cycle 4.
- Illegal opcode (16'h0000): `illegal` and `done` pulse in cycle 3; no enable asserted at any point.
- Assert reset during EXEC of ADD: all outputs go to 0 immediately; `instr_ready` reaches 1 one cycle after release; the next MOV completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer.
// State encoding, opcodes, ALU ops and instruction field positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WR_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WR_C,
    S_FAULT
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;

  localparam int OPC_LO = 13;
  localparam int OP_LO  = 11;
  localparam int RN_LO  = 8;
  localparam int RD_LO  = 5;
  localparam int RM_LO  = 0;
  localparam int IMM_LO = 0;

endpackage

// File: rtl/alu_sequencer_instr_decode.sv
// Combinational field extraction and classification of an instruction.
// in: instr[15:0]; out: fields, instruction-class flags, legal.
module instr_decode
  import alu_seq_pkg::*;
(
  input  logic [15:0] instr,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [7:0]  imm8,
  output logic        is_mov_imm,
  output logic        is_mov_reg,
  output logic        is_cmp,
  output logic        is_mvn,
  output logic        uses_a,
  output logic        legal
);

  logic [2:0] opc;
  logic       is_alu;
  logic       unused_bits;

  assign opc  = instr[OPC_LO +: 3];
  assign op   = instr[OP_LO  +: 2];
  assign rn   = instr[RN_LO  +: 3];
  assign rd   = instr[RD_LO  +: 3];
  assign rm   = instr[RM_LO  +: 3];
  assign imm8 = instr[IMM_LO +: 8];

  assign unused_bits = ^instr[4:3];

  assign is_alu     = (opc == OPC_ALU);
  assign is_mov_imm = (opc == OPC_MOV) && (op == MOV_IMM);
  assign is_mov_reg = (opc == OPC_MOV) && (op == MOV_REG);
  assign is_cmp     = is_alu && (op == ALU_SUB);
  assign is_mvn     = is_alu && (op == ALU_NOTB);
  assign uses_a     = is_alu && (op != ALU_NOTB);
  assign legal      = is_alu || is_mov_imm || is_mov_reg;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller stepping the register-file/ALU datapath.
// in: clk, reset, instr/instr_valid; out: instr_ready, done, illegal, datapath controls, sximm8.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int K = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  instr,
  input  logic         instr_valid,
  output logic         instr_ready,
  output logic         done,
  output logic         illegal,
  output logic [2:0]   readnum,
  output logic [2:0]   writenum,
  output logic         write,
  output logic         loada,
  output logic         loadb,
  output logic         loadc,
  output logic         loads,
  output logic         asel,
  output logic         vsel,
  output logic [1:0]   alu_op,
  output logic [K-1:0] sximm8
);

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        fwait_q, fwait_d;

  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [7:0] imm8;
  logic       is_mov_imm, is_mov_reg, is_cmp, is_mvn;
  logic       uses_a, legal;
  logic [1:0] op_eff;

  instr_decode u_dec (
    .instr      (instr_q),
    .op         (op),
    .rn         (rn),
    .rd         (rd),
    .rm         (rm),
    .imm8       (imm8),
    .is_mov_imm (is_mov_imm),
    .is_mov_reg (is_mov_reg),
    .is_cmp     (is_cmp),
    .is_mvn     (is_mvn),
    .uses_a     (uses_a),
    .legal      (legal)
  );

  assign op_eff = is_mov_reg ? ALU_ADD : op;
  assign sximm8 = {{(K-8){imm8[7]}}, imm8};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      fwait_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      fwait_q <= fwait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    fwait_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_mov_imm) begin
          state_d = S_WR_IMM;
        end else if (uses_a) begin
          state_d = S_GET_A;
        end else if (legal) begin
          state_d = S_GET_B;
        end else begin
          state_d = S_FAULT;
          fwait_d = 1'b1;
        end
      end
      S_WR_IMM: state_d = S_IDLE;
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_EXEC;
      S_EXEC:   state_d = is_cmp ? S_IDLE : S_WR_C;
      S_WR_C:   state_d = S_IDLE;
      // FAULT spends one quiet cycle before reporting.
      S_FAULT:  state_d = fwait_q ? S_FAULT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    readnum     = 3'd0;
    writenum    = 3'd0;
    write       = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    asel        = 1'b0;
    vsel        = 1'b0;
    alu_op      = 2'b00;
    unique case (state_q)
      S_IDLE: instr_ready = !reset;
      S_DECODE: alu_op = op_eff;
      S_WR_IMM: begin
        vsel     = 1'b1;
        writenum = rn;
        write    = 1'b1;
        done     = 1'b1;
      end
      S_GET_A: begin
        alu_op  = op_eff;
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        alu_op  = op_eff;
        readnum = rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        alu_op = op_eff;
        asel   = is_mov_reg || is_mvn;
        loads  = 1'b1;
        loadc  = !is_cmp;
        done   = is_cmp;
      end
      S_WR_C: begin
        alu_op   = op_eff;
        writenum = rd;
        write    = 1'b1;
        done     = 1'b1;
      end
      S_FAULT: begin
        illegal = !fwait_q;
        done    = !fwait_q;
      end
      default: ;
    endcase
  end

endmodule
